// File: rtl/seg_display_capture.sv
// Two-digit seven-segment display monitor: debounces the multiplexed lines, decodes each digit and
// reports Value/Valid/Up/Down/Err STABLE_CYC+3 edges after the raw change; purely observing, no backpressure.
module seg_display_capture #(
  parameter int unsigned STABLE_CYC     = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       SegSel,
  input  logic       CA,
  input  logic       CB,
  input  logic       CC,
  input  logic       CD,
  input  logic       CE,
  input  logic       CF,
  input  logic       CG,
  output logic [7:0] Value,
  output logic       Valid,
  output logic       Up,
  output logic       Down,
  output logic       Err
);

  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYC);
  localparam logic [7:0] RUN_ACC = 8'(STABLE_CYC - 1);

  // Returns {legal, nibble} for a lit-high {a..g} pattern.
  function automatic logic [4:0] decode(input logic [6:0] lit);
    case (lit)
      7'b1111110: decode = {1'b1, 4'h0};
      7'b0110000: decode = {1'b1, 4'h1};
      7'b1101101: decode = {1'b1, 4'h2};
      7'b1111001: decode = {1'b1, 4'h3};
      7'b0110011: decode = {1'b1, 4'h4};
      7'b1011011: decode = {1'b1, 4'h5};
      7'b1011111: decode = {1'b1, 4'h6};
      7'b1110000: decode = {1'b1, 4'h7};
      7'b1111111: decode = {1'b1, 4'h8};
      7'b1111011: decode = {1'b1, 4'h9};
      7'b1110111: decode = {1'b1, 4'hA};
      7'b0011111: decode = {1'b1, 4'hB};
      7'b1001110: decode = {1'b1, 4'hC};
      7'b0111101: decode = {1'b1, 4'hD};
      7'b1001111: decode = {1'b1, 4'hE};
      7'b1000111: decode = {1'b1, 4'hF};
      default:    decode = 5'b0_0000;
    endcase
  endfunction

  logic [7:0] raw;
  logic [7:0] sync1_q, sync2_q, prev_q;
  logic [7:0] run_q, run_d;
  logic [3:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0] fresh_q, fresh_d;
  logic       bad_q, bad_d;
  logic       seen_q;
  logic [7:0] value_q;
  logic       valid_q, up_q, down_q, err_q;

  logic       same, accept, sel, complete;
  logic [6:0] lit;
  logic [4:0] dec;
  logic [7:0] frame;

  assign raw      = {SegSel, CA, CB, CC, CD, CE, CF, CG};
  assign same     = (sync2_q == prev_q);
  assign accept   = same && (run_q == RUN_ACC);
  assign sel      = sync2_q[7];
  assign lit      = SEG_ACTIVE_LOW ? ~sync2_q[6:0] : sync2_q[6:0];
  assign dec      = decode(lit);
  assign frame    = {slot1_q, slot0_q};
  assign complete = &fresh_q;

  always_comb begin
    run_d   = same ? ((run_q == RUN_MAX) ? run_q : run_q + 8'd1) : 8'd1;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    fresh_d = complete ? 2'b00 : fresh_q;
    bad_d   = 1'b0;
    // Blank patterns fall through untouched; only lit, undecodable ones are errors.
    if (accept && (lit != 7'd0)) begin
      if (dec[4]) begin
        if (sel) slot1_d = dec[3:0];
        else     slot0_d = dec[3:0];
        fresh_d[sel] = 1'b1;
      end else begin
        bad_d        = 1'b1;
        fresh_d[sel] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
      prev_q  <= 8'h00;
      run_q   <= 8'h00;
      slot0_q <= 4'h0;
      slot1_q <= 4'h0;
      fresh_q <= 2'b00;
      bad_q   <= 1'b0;
      seen_q  <= 1'b0;
      value_q <= 8'h00;
      valid_q <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      run_q   <= run_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      fresh_q <= fresh_d;
      bad_q   <= bad_d;
      seen_q  <= seen_q | complete;
      value_q <= complete ? frame : value_q;
      valid_q <= complete;
      up_q    <= complete && seen_q && (frame == value_q + 8'd1);
      down_q  <= complete && seen_q && (frame == value_q - 8'd1);
      err_q   <= bad_q;
    end
  end

  assign Value = value_q;
  assign Valid = valid_q;
  assign Up    = up_q;
  assign Down  = down_q;
  assign Err   = err_q;

endmodule

// File: tb/tb_seg_display_capture.sv
// Bench for seg_display_capture: directed scenarios plus random holds, checked every cycle
// against a run-length model of the raw input stream with a fixed three-edge output delay.
module tb_seg_display_capture;

  localparam int S      = 4;
  localparam bit ACT_LO = 1'b1;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       SegSel, CA, CB, CC, CD, CE, CF, CG;
  logic [7:0] Value;
  logic       Valid, Up, Down, Err;

  seg_display_capture #(.STABLE_CYC(S), .SEG_ACTIVE_LOW(ACT_LO)) dut (
    .Clk(Clk), .Rst(Rst), .SegSel(SegSel),
    .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
    .Value(Value), .Valid(Valid), .Up(Up), .Down(Down), .Err(Err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] value;
    logic       valid;
    logic       up;
    logic       down;
    logic       err;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   valid_cnt = 0, up_cnt = 0, down_cnt = 0, err_cnt = 0, last_valid_cyc = 0;
  logic [6:0] glyph [16];

  // Reference model state: raw run length, per-digit slots and the last reported value.
  exp_t       exp_q[$];
  int         run_len;
  logic       have_prev;
  logic [7:0] prev_raw;
  logic [3:0] m_slot [2];
  logic [1:0] m_fresh;
  logic [7:0] m_value;
  logic       m_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] seg(input logic s, input logic [6:0] l);
    return {s, ACT_LO ? ~l : l};
  endfunction

  function automatic int glyph_idx(input logic [6:0] l);
    for (int i = 0; i < 16; i++) if (glyph[i] == l) return i;
    return -1;
  endfunction

  task automatic set_raw(input logic [7:0] r);
    {SegSel, CA, CB, CC, CD, CE, CF, CG} = r;
  endtask

  task automatic model_reset();
    exp_t z;
    z = '0;
    exp_q.delete();
    repeat (3) exp_q.push_back(z);
    run_len   = 0;
    have_prev = 1'b0;
    prev_raw  = 8'h00;
    m_slot[0] = 4'h0;
    m_slot[1] = 4'h0;
    m_fresh   = 2'b00;
    m_value   = 8'h00;
    m_seen    = 1'b0;
  endtask

  // A raw pattern held for S consecutive edges is accepted; its effect shows 3 edges after the S-th.
  task automatic model_step(input logic [7:0] r);
    exp_t       e;
    logic [6:0] l;
    logic [7:0] nv;
    logic       s;
    int         gi;
    if (have_prev && r == prev_raw) begin
      if (run_len <= S) run_len++;
    end else begin
      run_len = 1;
    end
    have_prev = 1'b1;
    prev_raw  = r;
    e = '0;
    e.value = m_value;
    if (run_len == S) begin
      s  = r[7];
      l  = ACT_LO ? ~r[6:0] : r[6:0];
      gi = glyph_idx(l);
      if (l != 7'd0) begin
        if (gi < 0) begin
          e.err      = 1'b1;
          m_fresh[s] = 1'b0;
        end else begin
          m_slot[s]  = gi[3:0];
          m_fresh[s] = 1'b1;
        end
      end
      if (m_fresh == 2'b11) begin
        nv      = {m_slot[1], m_slot[0]};
        e.valid = 1'b1;
        e.up    = m_seen && (nv == 8'(m_value + 8'd1));
        e.down  = m_seen && (nv == 8'(m_value - 8'd1));
        m_value = nv;
        e.value = nv;
        m_fresh = 2'b00;
        m_seen  = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic [7:0] r);
    exp_t e;
    set_raw(r);
    model_step(r);
    @(posedge Clk);
    cyc++;
    @(negedge Clk);
    e = exp_q.pop_front();
    check("outs", {20'd0, Value, Valid, Up, Down, Err}, {20'd0, e});
    if (Valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (Up)   up_cnt++;
    if (Down) down_cnt++;
    if (Err)  err_cnt++;
  endtask

  task automatic send_digit(input logic s, input int nib, input int n);
    repeat (n) tick(seg(s, glyph[nib]));
  endtask

  task automatic send_frame(input logic [7:0] v);
    send_digit(1'b0, int'(v[3:0]), 8);
    send_digit(1'b1, int'(v[7:4]), 8);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(seg(1'b0, 7'd0));
  endtask

  task automatic do_reset(input int n);
    Rst = 1'b0;
    #1;
    check("rst_async", {20'd0, Value, Valid, Up, Down, Err}, 32'd0);
    for (int i = 0; i < n; i++) begin
      set_raw(8'($urandom));
      @(posedge Clk);
      @(negedge Clk);
      check("rst_outs", {20'd0, Value, Valid, Up, Down, Err}, 32'd0);
    end
    set_raw(seg(1'b0, 7'd0));
    Rst = 1'b1;
    model_reset();
  endtask

  int         c0, v0, u0, d0, e0, k, len;
  logic       rs;
  logic [6:0] rl;

  initial begin
    glyph = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
              7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    Rst = 1'b0;
    set_raw(8'h00);
    @(negedge Clk);
    do_reset(5);

    // Quiet release: nothing should pulse.
    idle(12);
    check("idle_valid", valid_cnt, 0);
    check("idle_err", err_cnt, 0);

    // Basic frame: digit0 "3", digit1 "A".
    send_digit(1'b0, 3, 8);
    c0 = cyc + 1;
    send_digit(1'b1, 10, 8);
    check("basic_value", Value, 8'hA3);
    check("basic_valid_cnt", valid_cnt, 1);
    check("basic_latency", last_valid_cyc, c0 + 6);
    check("basic_updown", up_cnt + down_cnt, 0);

    // Counting up and down, including wrap.
    u0 = up_cnt; d0 = down_cnt;
    send_frame(8'h0E);
    send_frame(8'h0F);
    send_frame(8'h10);
    send_frame(8'h0F);
    check("count_up", up_cnt - u0, 2);
    check("count_down", down_cnt - d0, 1);
    u0 = up_cnt; d0 = down_cnt;
    send_frame(8'hFF);
    send_frame(8'h00);
    send_frame(8'hFF);
    check("wrap_up", up_cnt - u0, 1);
    check("wrap_down", down_cnt - d0, 1);
    check("wrap_value", Value, 8'hFF);

    // Glitching segment d every 2 cycles must not be accepted.
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i < 5; i++) begin
      repeat (2) tick(seg(1'b0, 7'b1111111));
      repeat (2) tick(seg(1'b0, 7'b1110111));
    end
    idle(6);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_err", err_cnt - e0, 0);
    send_digit(1'b0, 8, 8);
    send_digit(1'b1, 1, 8);
    check("glitch_recover", Value, 8'h18);
    check("glitch_once", valid_cnt - v0, 1);

    // Illegal glyph on digit0 kills the pending digit0.
    v0 = valid_cnt; e0 = err_cnt;
    repeat (8) tick(seg(1'b0, 7'b1010101));
    check("illegal_err", err_cnt - e0, 1);
    check("illegal_value", Value, 8'h18);
    send_digit(1'b1, 3, 8);
    check("illegal_novalid", valid_cnt - v0, 0);
    send_digit(1'b0, 4, 8);
    check("illegal_resend", Value, 8'h34);
    check("illegal_valid", valid_cnt - v0, 1);

    // Reset mid-frame discards the accepted digit0.
    send_digit(1'b0, 5, 8);
    do_reset(1);
    v0 = valid_cnt; u0 = up_cnt; d0 = down_cnt;
    send_digit(1'b1, 2, 8);
    idle(8);
    check("midrst_novalid", valid_cnt - v0, 0);
    send_digit(1'b0, 7, 8);
    check("midrst_value", Value, 8'h27);
    check("midrst_valid", valid_cnt - v0, 1);
    check("midrst_updown", (up_cnt - u0) + (down_cnt - d0), 0);

    // Random holds of varied length, glyphs, blanks and junk.
    for (int h = 0; h < 250; h++) begin
      k  = $urandom_range(0, 9);
      rs = 1'($urandom_range(0, 1));
      if (k < 7)       rl = glyph[$urandom_range(0, 15)];
      else if (k == 7) rl = 7'd0;
      else             rl = 7'($urandom);
      len = $urandom_range(1, 8);
      repeat (len) tick(seg(rs, rl));
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
